// File: rtl/gen_key.sv
// AES-128 key expansion.
// The eleven round keys are derived combinationally from the cipher key and
// captured together on every rising clock edge, giving exactly one cycle of
// latency and one complete key schedule per cycle.
// Output ordering: data_out[10] holds round 0 (the cipher key itself) and
// data_out[0] holds round 10.

module gen_key (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [127:0] data_in,
  output logic [127:0] data_out [10:0]
);

  // Forward AES S-box as a fixed 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] res;
    case (a)
      8'h00: res = 8'h63; 8'h01: res = 8'h7c; 8'h02: res = 8'h77; 8'h03: res = 8'h7b; 8'h04: res = 8'hf2; 8'h05: res = 8'h6b; 8'h06: res = 8'h6f; 8'h07: res = 8'hc5;
      8'h08: res = 8'h30; 8'h09: res = 8'h01; 8'h0a: res = 8'h67; 8'h0b: res = 8'h2b; 8'h0c: res = 8'hfe; 8'h0d: res = 8'hd7; 8'h0e: res = 8'hab; 8'h0f: res = 8'h76;
      8'h10: res = 8'hca; 8'h11: res = 8'h82; 8'h12: res = 8'hc9; 8'h13: res = 8'h7d; 8'h14: res = 8'hfa; 8'h15: res = 8'h59; 8'h16: res = 8'h47; 8'h17: res = 8'hf0;
      8'h18: res = 8'had; 8'h19: res = 8'hd4; 8'h1a: res = 8'ha2; 8'h1b: res = 8'haf; 8'h1c: res = 8'h9c; 8'h1d: res = 8'ha4; 8'h1e: res = 8'h72; 8'h1f: res = 8'hc0;
      8'h20: res = 8'hb7; 8'h21: res = 8'hfd; 8'h22: res = 8'h93; 8'h23: res = 8'h26; 8'h24: res = 8'h36; 8'h25: res = 8'h3f; 8'h26: res = 8'hf7; 8'h27: res = 8'hcc;
      8'h28: res = 8'h34; 8'h29: res = 8'ha5; 8'h2a: res = 8'he5; 8'h2b: res = 8'hf1; 8'h2c: res = 8'h71; 8'h2d: res = 8'hd8; 8'h2e: res = 8'h31; 8'h2f: res = 8'h15;
      8'h30: res = 8'h04; 8'h31: res = 8'hc7; 8'h32: res = 8'h23; 8'h33: res = 8'hc3; 8'h34: res = 8'h18; 8'h35: res = 8'h96; 8'h36: res = 8'h05; 8'h37: res = 8'h9a;
      8'h38: res = 8'h07; 8'h39: res = 8'h12; 8'h3a: res = 8'h80; 8'h3b: res = 8'he2; 8'h3c: res = 8'heb; 8'h3d: res = 8'h27; 8'h3e: res = 8'hb2; 8'h3f: res = 8'h75;
      8'h40: res = 8'h09; 8'h41: res = 8'h83; 8'h42: res = 8'h2c; 8'h43: res = 8'h1a; 8'h44: res = 8'h1b; 8'h45: res = 8'h6e; 8'h46: res = 8'h5a; 8'h47: res = 8'ha0;
      8'h48: res = 8'h52; 8'h49: res = 8'h3b; 8'h4a: res = 8'hd6; 8'h4b: res = 8'hb3; 8'h4c: res = 8'h29; 8'h4d: res = 8'he3; 8'h4e: res = 8'h2f; 8'h4f: res = 8'h84;
      8'h50: res = 8'h53; 8'h51: res = 8'hd1; 8'h52: res = 8'h00; 8'h53: res = 8'hed; 8'h54: res = 8'h20; 8'h55: res = 8'hfc; 8'h56: res = 8'hb1; 8'h57: res = 8'h5b;
      8'h58: res = 8'h6a; 8'h59: res = 8'hcb; 8'h5a: res = 8'hbe; 8'h5b: res = 8'h39; 8'h5c: res = 8'h4a; 8'h5d: res = 8'h4c; 8'h5e: res = 8'h58; 8'h5f: res = 8'hcf;
      8'h60: res = 8'hd0; 8'h61: res = 8'hef; 8'h62: res = 8'haa; 8'h63: res = 8'hfb; 8'h64: res = 8'h43; 8'h65: res = 8'h4d; 8'h66: res = 8'h33; 8'h67: res = 8'h85;
      8'h68: res = 8'h45; 8'h69: res = 8'hf9; 8'h6a: res = 8'h02; 8'h6b: res = 8'h7f; 8'h6c: res = 8'h50; 8'h6d: res = 8'h3c; 8'h6e: res = 8'h9f; 8'h6f: res = 8'ha8;
      8'h70: res = 8'h51; 8'h71: res = 8'ha3; 8'h72: res = 8'h40; 8'h73: res = 8'h8f; 8'h74: res = 8'h92; 8'h75: res = 8'h9d; 8'h76: res = 8'h38; 8'h77: res = 8'hf5;
      8'h78: res = 8'hbc; 8'h79: res = 8'hb6; 8'h7a: res = 8'hda; 8'h7b: res = 8'h21; 8'h7c: res = 8'h10; 8'h7d: res = 8'hff; 8'h7e: res = 8'hf3; 8'h7f: res = 8'hd2;
      8'h80: res = 8'hcd; 8'h81: res = 8'h0c; 8'h82: res = 8'h13; 8'h83: res = 8'hec; 8'h84: res = 8'h5f; 8'h85: res = 8'h97; 8'h86: res = 8'h44; 8'h87: res = 8'h17;
      8'h88: res = 8'hc4; 8'h89: res = 8'ha7; 8'h8a: res = 8'h7e; 8'h8b: res = 8'h3d; 8'h8c: res = 8'h64; 8'h8d: res = 8'h5d; 8'h8e: res = 8'h19; 8'h8f: res = 8'h73;
      8'h90: res = 8'h60; 8'h91: res = 8'h81; 8'h92: res = 8'h4f; 8'h93: res = 8'hdc; 8'h94: res = 8'h22; 8'h95: res = 8'h2a; 8'h96: res = 8'h90; 8'h97: res = 8'h88;
      8'h98: res = 8'h46; 8'h99: res = 8'hee; 8'h9a: res = 8'hb8; 8'h9b: res = 8'h14; 8'h9c: res = 8'hde; 8'h9d: res = 8'h5e; 8'h9e: res = 8'h0b; 8'h9f: res = 8'hdb;
      8'ha0: res = 8'he0; 8'ha1: res = 8'h32; 8'ha2: res = 8'h3a; 8'ha3: res = 8'h0a; 8'ha4: res = 8'h49; 8'ha5: res = 8'h06; 8'ha6: res = 8'h24; 8'ha7: res = 8'h5c;
      8'ha8: res = 8'hc2; 8'ha9: res = 8'hd3; 8'haa: res = 8'hac; 8'hab: res = 8'h62; 8'hac: res = 8'h91; 8'had: res = 8'h95; 8'hae: res = 8'he4; 8'haf: res = 8'h79;
      8'hb0: res = 8'he7; 8'hb1: res = 8'hc8; 8'hb2: res = 8'h37; 8'hb3: res = 8'h6d; 8'hb4: res = 8'h8d; 8'hb5: res = 8'hd5; 8'hb6: res = 8'h4e; 8'hb7: res = 8'ha9;
      8'hb8: res = 8'h6c; 8'hb9: res = 8'h56; 8'hba: res = 8'hf4; 8'hbb: res = 8'hea; 8'hbc: res = 8'h65; 8'hbd: res = 8'h7a; 8'hbe: res = 8'hae; 8'hbf: res = 8'h08;
      8'hc0: res = 8'hba; 8'hc1: res = 8'h78; 8'hc2: res = 8'h25; 8'hc3: res = 8'h2e; 8'hc4: res = 8'h1c; 8'hc5: res = 8'ha6; 8'hc6: res = 8'hb4; 8'hc7: res = 8'hc6;
      8'hc8: res = 8'he8; 8'hc9: res = 8'hdd; 8'hca: res = 8'h74; 8'hcb: res = 8'h1f; 8'hcc: res = 8'h4b; 8'hcd: res = 8'hbd; 8'hce: res = 8'h8b; 8'hcf: res = 8'h8a;
      8'hd0: res = 8'h70; 8'hd1: res = 8'h3e; 8'hd2: res = 8'hb5; 8'hd3: res = 8'h66; 8'hd4: res = 8'h48; 8'hd5: res = 8'h03; 8'hd6: res = 8'hf6; 8'hd7: res = 8'h0e;
      8'hd8: res = 8'h61; 8'hd9: res = 8'h35; 8'hda: res = 8'h57; 8'hdb: res = 8'hb9; 8'hdc: res = 8'h86; 8'hdd: res = 8'hc1; 8'hde: res = 8'h1d; 8'hdf: res = 8'h9e;
      8'he0: res = 8'he1; 8'he1: res = 8'hf8; 8'he2: res = 8'h98; 8'he3: res = 8'h11; 8'he4: res = 8'h69; 8'he5: res = 8'hd9; 8'he6: res = 8'h8e; 8'he7: res = 8'h94;
      8'he8: res = 8'h9b; 8'he9: res = 8'h1e; 8'hea: res = 8'h87; 8'heb: res = 8'he9; 8'hec: res = 8'hce; 8'hed: res = 8'h55; 8'hee: res = 8'h28; 8'hef: res = 8'hdf;
      8'hf0: res = 8'h8c; 8'hf1: res = 8'ha1; 8'hf2: res = 8'h89; 8'hf3: res = 8'h0d; 8'hf4: res = 8'hbf; 8'hf5: res = 8'he6; 8'hf6: res = 8'h42; 8'hf7: res = 8'h68;
      8'hf8: res = 8'h41; 8'hf9: res = 8'h99; 8'hfa: res = 8'h2d; 8'hfb: res = 8'h0f; 8'hfc: res = 8'hb0; 8'hfd: res = 8'h54; 8'hfe: res = 8'hbb; 8'hff: res = 8'h16;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  // Round constant byte for rounds 1..10.
  function automatic logic [7:0] rcon_byte(input logic [3:0] rnd);
    logic [7:0] res;
    case (rnd)
      4'd1:    res = 8'h01;
      4'd2:    res = 8'h02;
      4'd3:    res = 8'h04;
      4'd4:    res = 8'h08;
      4'd5:    res = 8'h10;
      4'd6:    res = 8'h20;
      4'd7:    res = 8'h40;
      4'd8:    res = 8'h80;
      4'd9:    res = 8'h1b;
      4'd10:   res = 8'h36;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  // Next-cycle round keys, indexed the same way as data_out.
  logic [127:0] next_key_s  [10:0];
  logic [127:0] round_key_r [10:0];

  // One generate stage per round. Each stage derives its four words from the
  // previous stage only, so the chain is a pure feed-forward XOR/S-box network.
  for (genvar r = 0; r <= 10; r++) begin : g_round
    logic [127:0] rk_s;

    if (r == 0) begin : g_init
      assign rk_s = data_in;
    end else begin : g_step
      localparam logic [3:0] RND = 4'(r);
      logic [31:0] p0_s, p1_s, p2_s, p3_s;
      logic [31:0] rot_s, sub_s;
      logic [31:0] w0_s, w1_s, w2_s, w3_s;

      assign {p0_s, p1_s, p2_s, p3_s} = g_round[r-1].rk_s;
      // RotWord: a0 (most significant byte) moves to the bottom.
      assign rot_s = {p3_s[23:0], p3_s[31:24]};
      // SubWord: four independent S-box lookups for this round.
      assign sub_s = {sbox(rot_s[31:24]), sbox(rot_s[23:16]),
                      sbox(rot_s[15:8]),  sbox(rot_s[7:0])};
      assign w0_s = p0_s ^ sub_s ^ {rcon_byte(RND), 24'h000000};
      assign w1_s = p1_s ^ w0_s;
      assign w2_s = p2_s ^ w1_s;
      assign w3_s = p3_s ^ w2_s;
      assign rk_s = {w0_s, w1_s, w2_s, w3_s};
    end

    // Round r lands on output slot 10-r.
    assign next_key_s[10-r] = rk_s;
  end

  // Capture all eleven round keys every cycle; reset clears them immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < 11; k++) begin
        round_key_r[k] <= 128'h0;
      end
    end else begin
      for (int k = 0; k < 11; k++) begin
        round_key_r[k] <= next_key_s[k];
      end
    end
  end

  assign data_out = round_key_r;

endmodule

// File: tb/tb_gen_key.sv
// Self-checking bench for gen_key. The reference model derives the S-box from
// GF(2^8) inversion plus the affine map and generates Rcon by repeated
// doubling, then runs the word recurrence on plain arrays.

module tb_gen_key;

  logic         clk;
  logic         n_rst;
  logic [127:0] data_in;
  logic [127:0] data_out [10:0];

  int n_checks;
  int n_errors;

  logic [7:0]   ref_sbox [256];
  logic [127:0] exp_rk   [11];

  gen_key dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  // S-box from first principles: multiplicative inverse, then affine transform.
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      ref_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  // Key schedule on a word array; result stored by output slot (10 - round).
  function automatic void build_expect(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[10-r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 11; k++) check_val($sformatf("%s[%0d]", tag, k), data_out[k], exp_rk[k]);
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 11; k++) check_val($sformatf("%s[%0d]", tag, k), data_out[k], 128'h0);
  endtask

  task automatic load_key(input logic [127:0] key);
    @(negedge clk);
    data_in = key;
    @(posedge clk);
    #1;
    build_expect(key);
  endtask

  localparam logic [127:0] KEY_A = 128'hAFADB59705579CCE9FD3644F45E3008B;
  localparam logic [127:0] KEY_B = 128'h61CD359550D93D14487441A0AD6624C8;

  task automatic check_key_a(input string tag);
    check_val({tag, "_r0"},  data_out[10], KEY_A);
    check_val({tag, "_r1"},  data_out[9],  128'hBFCE88F9BA991437254A707860A970F3);
    check_val({tag, "_r2"},  data_out[8],  128'h6E9F8529D406911EF14CE16691E59195);
    check_val({tag, "_r3"},  data_out[7],  128'hB31EAFA867183EB69654DFD007B14E45);
    check_val({tag, "_r4"},  data_out[6],  128'h7331C16D1429FFDB827D200B85CC6E4E);
    check_val({tag, "_r8"},  data_out[2],  128'hDA3EB0AF430C540355223DBCF7268674);
    check_val({tag, "_r10"}, data_out[0],  128'h40C7DCC935B1AA0D15E5E175C2972C79);
  endtask

  initial begin
    logic [127:0] k;
    n_checks = 0;
    n_errors = 0;
    build_sbox();

    // Asynchronous reset with no clock edge in between.
    n_rst   = 1'b1;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    #1;
    n_rst = 1'b0;
    #1;
    check_zero("rst_async");

    // Reset dominates clock edges.
    repeat (2) begin
      @(negedge clk);
      data_in = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk);
    #1;
    check_zero("rst_hold");

    // First edge after release loads the known vector.
    @(negedge clk);
    n_rst   = 1'b1;
    data_in = KEY_A;
    @(posedge clk);
    #1;
    build_expect(KEY_A);
    check_key_a("vec_a");
    check_all("vec_a_model");

    // Second known vector on the next edge.
    load_key(KEY_B);
    check_val("vec_b_r10", data_out[0], 128'hE157ED12FBC2426508AFE3C9E7BCA148);
    check_val("vec_b_r0", data_out[10], KEY_B);
    check_all("vec_b_model");

    // All-zero key.
    load_key(128'h0);
    check_val("zero_r1", data_out[9], 128'h62636363626363636263636362636363);
    check_val("zero_r10", data_out[0], 128'hB4EF5BCB3E92E21123E951CF6F8F188E);
    check_all("zero_model");

    // Input change between edges must not reach the outputs until the edge.
    data_in = {$urandom, $urandom, $urandom, $urandom};
    k = data_in;
    #2;
    check_all("hold_mid");
    @(posedge clk);
    #1;
    build_expect(k);
    check_all("hold_next");

    // Mid-stream reset clears at once, then one edge restores the vector.
    load_key(KEY_A);
    check_key_a("pre_rst");
    #2;
    n_rst = 1'b0;
    #1;
    check_zero("mid_rst");
    @(posedge clk);
    #1;
    check_zero("mid_rst_edge");
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check_key_a("restore");

    // Back-to-back random keys, one per cycle.
    for (int n = 0; n < 40; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      if (n == 5) k = {128{1'b1}};
      load_key(k);
      check_all($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
